// File: rtl/morse_encoder_if.sv
// Character handshake and key-line bundle for the Morse transmitter.
// Host side drives start/char_code/enable; encoder returns status and tone.
interface morse_encoder_if;
  logic       enable;
  logic       start;
  logic [5:0] char_code;
  logic       ready;
  logic       tone_out;
  logic       done;
  logic       err;

  modport master (
    output enable,
    output start,
    output char_code,
    input  ready,
    input  tone_out,
    input  done,
    input  err
  );

  modport slave (
    input  enable,
    input  start,
    input  char_code,
    output ready,
    output tone_out,
    output done,
    output err
  );
endinterface

// File: rtl/morse_encoder.sv
// Morse transmitter: one character code in, keyed tone line out.
// Unit prescaler plus small unit counter time marks and gaps.
module morse_encoder #(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int CNT_W       = 24
) (
  input logic            clk,
  input logic            rst,
  morse_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    EGAP,
    CGAP,
    WGAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(UNIT_CYCLES - 1);
  localparam logic [5:0] SPACE_CODE = 6'd36;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       units_q, units_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       len_q, len_d;
  logic [4:0]       pat_q, pat_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [7:0] rom;
  logic       rom_ok;
  logic       is_space;
  logic       tick;
  logic [2:0] last_unit;
  logic       unit_end;

  // {len, pattern left-aligned}; pattern MSB is first element, 1 = dash
  always_comb begin
    rom    = 8'h00;
    rom_ok = 1'b1;
    unique case (bus.char_code)
      6'd0:  rom = {3'd2, 5'b01000};
      6'd1:  rom = {3'd4, 5'b10000};
      6'd2:  rom = {3'd4, 5'b10100};
      6'd3:  rom = {3'd3, 5'b10000};
      6'd4:  rom = {3'd1, 5'b00000};
      6'd5:  rom = {3'd4, 5'b00100};
      6'd6:  rom = {3'd3, 5'b11000};
      6'd7:  rom = {3'd4, 5'b00000};
      6'd8:  rom = {3'd2, 5'b00000};
      6'd9:  rom = {3'd4, 5'b01110};
      6'd10: rom = {3'd3, 5'b10100};
      6'd11: rom = {3'd4, 5'b01000};
      6'd12: rom = {3'd2, 5'b11000};
      6'd13: rom = {3'd2, 5'b10000};
      6'd14: rom = {3'd3, 5'b11100};
      6'd15: rom = {3'd4, 5'b01100};
      6'd16: rom = {3'd4, 5'b11010};
      6'd17: rom = {3'd3, 5'b01000};
      6'd18: rom = {3'd3, 5'b00000};
      6'd19: rom = {3'd1, 5'b10000};
      6'd20: rom = {3'd3, 5'b00100};
      6'd21: rom = {3'd4, 5'b00010};
      6'd22: rom = {3'd3, 5'b01100};
      6'd23: rom = {3'd4, 5'b10010};
      6'd24: rom = {3'd4, 5'b10110};
      6'd25: rom = {3'd4, 5'b11000};
      6'd26: rom = {3'd5, 5'b11111};
      6'd27: rom = {3'd5, 5'b01111};
      6'd28: rom = {3'd5, 5'b00111};
      6'd29: rom = {3'd5, 5'b00011};
      6'd30: rom = {3'd5, 5'b00001};
      6'd31: rom = {3'd5, 5'b00000};
      6'd32: rom = {3'd5, 5'b10000};
      6'd33: rom = {3'd5, 5'b11000};
      6'd34: rom = {3'd5, 5'b11100};
      6'd35: rom = {3'd5, 5'b11110};
      default: rom_ok = 1'b0;
    endcase
  end

  assign is_space = (bus.char_code == SPACE_CODE);
  assign tick     = bus.enable && (cnt_q == CNT_MAX);

  always_comb begin
    last_unit = 3'd0;
    unique case (state_q)
      MARK:    last_unit = pat_q[4] ? 3'd2 : 3'd0;
      CGAP:    last_unit = 3'd2;
      WGAP:    last_unit = 3'd6;
      default: last_unit = 3'd0;
    endcase
  end

  assign unit_end = tick && (units_q == last_unit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    units_d = units_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pat_d   = pat_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.enable) begin
      if (state_q != IDLE) begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) units_d = units_q + 3'd1;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              rom_ok: begin
                state_d = MARK;
                len_d   = rom[7:5];
                pat_d   = rom[4:0];
                idx_d   = 3'd0;
                cnt_d   = '0;
                units_d = 3'd0;
              end
              is_space: begin
                state_d = WGAP;
                cnt_d   = '0;
                units_d = 3'd0;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        MARK: begin
          if (unit_end) begin
            cnt_d   = '0;
            units_d = 3'd0;
            if (idx_q < len_q - 3'd1) begin
              state_d = EGAP;
              idx_d   = idx_q + 3'd1;
              pat_d   = {pat_q[3:0], 1'b0};
            end else begin
              state_d = CGAP;
            end
          end
        end
        EGAP: begin
          if (unit_end) begin
            state_d = MARK;
            cnt_d   = '0;
            units_d = 3'd0;
          end
        end
        CGAP, WGAP: begin
          if (unit_end) begin
            state_d = IDLE;
            cnt_d   = '0;
            units_d = 3'd0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      units_q <= 3'd0;
      idx_q   <= 3'd0;
      len_q   <= 3'd0;
      pat_q   <= 5'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready    = (state_q == IDLE) && bus.enable;
  assign bus.tone_out = (state_q == MARK);
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder with UNIT_CYCLES=4.
// Cycle k = the k-th cycle after the accepting clock edge.
module tb_morse_encoder;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  logic tlog [0:255];
  logic rlog [0:255];
  int   dcyc, highs, marks, cnt;

  morse_encoder_if bus ();

  morse_encoder #(
    .UNIT_CYCLES(4),
    .CNT_W      (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [5:0] code);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.char_code = code;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run(input int budget,
                     input int poke,
                     input int en_off,
                     input int en_len);
    logic prev;
    prev  = 1'b0;
    dcyc  = 0;
    highs = 0;
    marks = 0;
    for (int k = 1; k <= budget && dcyc == 0; k++) begin
      @(negedge clk);
      tlog[k] = bus.tone_out;
      rlog[k] = bus.ready;
      if (bus.tone_out) highs++;
      if (bus.tone_out && !prev) marks++;
      prev = bus.tone_out;
      if (bus.done) dcyc = k;
      bus.start = (k == poke);
      if (k == poke) bus.char_code = 6'd4;
      if (k == en_off) bus.enable = 1'b0;
      if (k == en_off + en_len) bus.enable = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.enable    = 1'b1;
    bus.start     = 1'b0;
    bus.char_code = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_tone", bus.tone_out, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b1;

    // E: 4 high, 12 low, done at 17
    send(6'd4);
    run(100, 0, 0, 0);
    check("E_done", dcyc, 17);
    check("E_highs", highs, 4);
    check("E_c1", tlog[1], 1);
    check("E_c4", tlog[4], 1);
    check("E_c5", tlog[5], 0);
    check("E_rdy1", rlog[1], 0);

    // A: high 4, low 4, high 12, low 12
    send(6'd0);
    run(100, 0, 0, 0);
    check("A_done", dcyc, 33);
    check("A_highs", highs, 16);
    check("A_marks", marks, 2);
    check("A_c4", tlog[4], 1);
    check("A_c5", tlog[5], 0);
    check("A_c8", tlog[8], 0);
    check("A_c9", tlog[9], 1);
    check("A_c20", tlog[20], 1);
    check("A_c21", tlog[21], 0);

    // '0': five dashes, start poked at cycle 20 ignored
    send(6'd26);
    run(200, 20, 0, 0);
    check("D0_done", dcyc, 89);
    check("D0_highs", highs, 60);
    check("D0_marks", marks, 5);
    check("D0_c12", tlog[12], 1);
    check("D0_c13", tlog[13], 0);
    check("D0_c17", tlog[17], 1);

    // word space: ready low 28 cycles, tone never on
    send(6'd36);
    run(100, 0, 0, 0);
    check("SP_done", dcyc, 29);
    check("SP_highs", highs, 0);
    cnt = 0;
    for (int k = 1; k <= 28; k++)
      if (!rlog[k]) cnt++;
    check("SP_rdylow", cnt, 28);

    // invalid code 50: err pulse only
    send(6'd50);
    @(negedge clk);
    check("INV_err1", bus.err, 1);
    check("INV_rdy", bus.ready, 1);
    check("INV_tone", bus.tone_out, 0);
    check("INV_done", bus.done, 0);
    @(negedge clk);
    check("INV_err2", bus.err, 0);

    // enable low in IDLE: ready drops, start ignored
    @(negedge clk);
    bus.enable = 1'b0;
    #1 check("ENI_rdy", bus.ready, 0);
    bus.start     = 1'b1;
    bus.char_code = 6'd19;
    @(negedge clk);
    bus.start = 1'b0;
    check("ENI_tone", bus.tone_out, 0);
    bus.enable = 1'b1;
    #1 check("ENI_rdy2", bus.ready, 1);

    // T with enable low 10 cycles during the mark
    send(6'd19);
    run(100, 0, 3, 10);
    check("T_en_highs", highs, 22);
    check("T_en_done", dcyc, 35);
    check("T_en_marks", marks, 1);

    // reset mid-dash of K
    send(6'd10);
    run(5, 0, 0, 0);
    check("K_c5", tlog[5], 1);
    #2 rst = 1'b0;
    #1;
    check("K_rst_tone", bus.tone_out, 0);
    check("K_rst_rdy", bus.ready, 1);
    check("K_rst_done", bus.done, 0);
    @(negedge clk);
    rst = 1'b1;

    // E then T back-to-back, start in the done cycle
    send(6'd4);
    run(100, 0, 0, 0);
    check("BB_E_done", dcyc, 17);
    bus.start     = 1'b1;
    bus.char_code = 6'd19;
    @(posedge clk);
    #1 bus.start = 1'b0;
    run(100, 0, 0, 0);
    check("BB_T_c1", tlog[1], 1);
    check("BB_T_rdy", rlog[1], 0);
    check("BB_T_highs", highs, 12);
    check("BB_T_done", dcyc, 25);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
